// File: rtl/regdisp_multi_disp_if.sv
// Register native interface bundle, NCH lanes wide so the same type serves
// the single upstream port and the fanned-out downstream channels.
interface regdisp_multi_disp_if #(
  parameter int NCH = 1,
  parameter int AW  = 48,
  parameter int DW  = 32
);
  logic [NCH-1:0]    req_vld;
  logic [NCH*AW-1:0] addr;
  logic [NCH-1:0]    wr_en;
  logic [NCH-1:0]    rd_en;
  logic [NCH*DW-1:0] wr_data;
  logic [NCH-1:0]    non_sec;
  logic [NCH-1:0]    soft_rst;
  logic [NCH-1:0]    ack_vld;
  logic [NCH-1:0]    err;
  logic [NCH*DW-1:0] rd_data;

  modport master (
    output req_vld, addr, wr_en, rd_en, wr_data, non_sec, soft_rst,
    input  ack_vld, err, rd_data
  );

  modport slave (
    input  req_vld, addr, wr_en, rd_en, wr_data, non_sec, soft_rst,
    output ack_vld, err, rd_data
  );
endinterface

// File: rtl/regdisp_multi_disp.sv
// Address-window dispatcher: one upstream register port fanned out to NUM_CH
// channels, with single-outstanding tracking, ack timeout and miss responses.
module regdisp_multi_disp #(
  parameter int                     NUM_CH             = 4,
  parameter int                     ADDR_WIDTH         = 48,
  parameter int                     DATA_WIDTH         = 32,
  parameter logic [NUM_CH*64-1:0]   CH_BASE            = {NUM_CH{64'h0}},
  parameter logic [NUM_CH*64-1:0]   CH_SIZE            = {NUM_CH{64'h1000}},
  parameter logic [NUM_CH*8-1:0]    CH_REM_BITS        = {NUM_CH{8'd12}},
  parameter logic [NUM_CH-1:0]      INSERT_FORWARD_FF  = {NUM_CH{1'b0}},
  parameter bit                     INSERT_BACKWARD_FF = 1'b0,
  parameter int                     TIMEOUT_CYCLES     = 256,
  parameter logic [DATA_WIDTH-1:0]  DUMMY_READ_DATA    = '0
) (
  input  logic                 regdisp_multi_disp_clk,
  input  logic                 regdisp_multi_disp_rst,
  regdisp_multi_disp_if.slave  upstream,
  regdisp_multi_disp_if.master downstream,
  output logic                 busy,
  output logic                 timeout_evt,
  output logic                 proto_viol
);

  localparam int LSB  = $clog2(DATA_WIDTH / 8);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {IDLE, WAIT_ACK, MISS_RSP} state_t;

  state_t            state_q;
  logic [CH_W-1:0]   chan_q;
  logic [31:0]       cnt_q;
  logic              protoViol_q;

  logic                         hit;
  logic [CH_W-1:0]              hitIdx;
  logic [63:0]                  addrWord;
  logic                         accept;
  logic [NUM_CH-1:0]            fwdReq, fwdWr, fwdRd, fwdNs;
  logic [NUM_CH*ADDR_WIDTH-1:0] fwdAddr;
  logic [NUM_CH*DATA_WIDTH-1:0] fwdData;
  logic                         selAck, selErr;
  logic [DATA_WIDTH-1:0]        selData;
  logic                         timeoutHit;
  logic                         rspVld_d, rspErr_d, toEvt_d;
  logic [DATA_WIDTH-1:0]        rspData_d;

  function automatic logic [ADDR_WIDTH-1:0] remMask(input int rem);
    logic [ADDR_WIDTH-1:0] m;
    m = '0;
    for (int b = 0; b < ADDR_WIDTH; b++) begin
      if (b < rem) m[b] = 1'b1;
    end
    return m;
  endfunction

  assign addrWord = 64'(upstream.addr[ADDR_WIDTH-1:LSB]);
  assign accept   = upstream.req_vld[0] && (state_q == IDLE);

  // Scanning downward lets the lowest-index window win when windows overlap.
  always_comb begin
    hit    = 1'b0;
    hitIdx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if ((addrWord >= (CH_BASE[i*64 +: 64] >> LSB)) &&
          (addrWord < ((CH_BASE[i*64 +: 64] + CH_SIZE[i*64 +: 64]) >> LSB))) begin
        hit    = 1'b1;
        hitIdx = CH_W'(i);
      end
    end
  end

  always_comb begin
    fwdReq  = '0;
    fwdWr   = '0;
    fwdRd   = '0;
    fwdNs   = '0;
    fwdAddr = '0;
    fwdData = '0;
    if (accept && hit) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (CH_W'(i) == hitIdx) begin
          fwdReq[i] = 1'b1;
          fwdWr[i]  = upstream.wr_en[0];
          fwdRd[i]  = upstream.rd_en[0];
          fwdNs[i]  = upstream.non_sec[0];
          fwdAddr[i*ADDR_WIDTH +: ADDR_WIDTH] =
            upstream.addr & remMask(int'(CH_REM_BITS[i*8 +: 8]));
          fwdData[i*DATA_WIDTH +: DATA_WIDTH] = upstream.wr_data;
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : gFwd
    if (INSERT_FORWARD_FF[g]) begin : gFf
      logic                  req_q, wr_q, rd_q, ns_q;
      logic [ADDR_WIDTH-1:0] addr_q;
      logic [DATA_WIDTH-1:0] data_q;
      always_ff @(posedge regdisp_multi_disp_clk or posedge regdisp_multi_disp_rst) begin
        if (regdisp_multi_disp_rst) begin
          req_q  <= 1'b0;
          wr_q   <= 1'b0;
          rd_q   <= 1'b0;
          ns_q   <= 1'b0;
          addr_q <= '0;
          data_q <= '0;
        end else begin
          req_q  <= fwdReq[g];
          wr_q   <= fwdWr[g];
          rd_q   <= fwdRd[g];
          ns_q   <= fwdNs[g];
          addr_q <= fwdAddr[g*ADDR_WIDTH +: ADDR_WIDTH];
          data_q <= fwdData[g*DATA_WIDTH +: DATA_WIDTH];
        end
      end
      assign downstream.req_vld[g] = req_q;
      assign downstream.wr_en[g]   = wr_q;
      assign downstream.rd_en[g]   = rd_q;
      assign downstream.non_sec[g] = ns_q;
      assign downstream.addr[g*ADDR_WIDTH +: ADDR_WIDTH]    = addr_q;
      assign downstream.wr_data[g*DATA_WIDTH +: DATA_WIDTH] = data_q;
    end else begin : gComb
      assign downstream.req_vld[g] = fwdReq[g];
      assign downstream.wr_en[g]   = fwdWr[g];
      assign downstream.rd_en[g]   = fwdRd[g];
      assign downstream.non_sec[g] = fwdNs[g];
      assign downstream.addr[g*ADDR_WIDTH +: ADDR_WIDTH]    = fwdAddr[g*ADDR_WIDTH +: ADDR_WIDTH];
      assign downstream.wr_data[g*DATA_WIDTH +: DATA_WIDTH] = fwdData[g*DATA_WIDTH +: DATA_WIDTH];
    end
    assign downstream.soft_rst[g] = upstream.soft_rst[0];
  end

  // Only the latched channel is listened to; everything else is dropped.
  always_comb begin
    selAck  = 1'b0;
    selErr  = 1'b0;
    selData = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (CH_W'(i) == chan_q) begin
        selAck  = downstream.ack_vld[i];
        selErr  = downstream.err[i];
        selData = downstream.rd_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign timeoutHit = (TIMEOUT_CYCLES != 0) && (cnt_q == 32'(TIMEOUT_CYCLES - 1));

  always_comb begin
    rspVld_d  = 1'b0;
    rspErr_d  = 1'b0;
    rspData_d = '0;
    toEvt_d   = 1'b0;
    case (state_q)
      MISS_RSP: begin
        rspVld_d  = 1'b1;
        rspErr_d  = 1'b1;
        rspData_d = DUMMY_READ_DATA;
      end
      WAIT_ACK: begin
        if (selAck) begin
          rspVld_d  = 1'b1;
          rspErr_d  = selErr;
          rspData_d = selData;
        end else if (timeoutHit) begin
          rspVld_d  = 1'b1;
          rspErr_d  = 1'b1;
          rspData_d = DUMMY_READ_DATA;
          toEvt_d   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge regdisp_multi_disp_clk or posedge regdisp_multi_disp_rst) begin
    if (regdisp_multi_disp_rst) begin
      state_q     <= IDLE;
      chan_q      <= '0;
      cnt_q       <= '0;
      protoViol_q <= 1'b0;
    end else begin
      if (upstream.req_vld[0] && (state_q != IDLE)) protoViol_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (upstream.req_vld[0]) begin
            if (hit) begin
              state_q <= WAIT_ACK;
              chan_q  <= hitIdx;
              cnt_q   <= '0;
            end else begin
              state_q <= MISS_RSP;
            end
          end
        end
        WAIT_ACK: begin
          if (selAck || timeoutHit) state_q <= IDLE;
          else                      cnt_q   <= cnt_q + 32'd1;
        end
        MISS_RSP: state_q <= IDLE;
        default:  state_q <= IDLE;
      endcase
    end
  end

  if (INSERT_BACKWARD_FF) begin : gBwdFf
    logic                  rspVld_q, rspErr_q, toEvt_q;
    logic [DATA_WIDTH-1:0] rspData_q;
    always_ff @(posedge regdisp_multi_disp_clk or posedge regdisp_multi_disp_rst) begin
      if (regdisp_multi_disp_rst) begin
        rspVld_q  <= 1'b0;
        rspErr_q  <= 1'b0;
        rspData_q <= '0;
        toEvt_q   <= 1'b0;
      end else begin
        rspVld_q  <= rspVld_d;
        rspErr_q  <= rspErr_d;
        rspData_q <= rspData_d;
        toEvt_q   <= toEvt_d;
      end
    end
    assign upstream.ack_vld = rspVld_q;
    assign upstream.err     = rspErr_q;
    assign upstream.rd_data = rspData_q;
    assign timeout_evt      = toEvt_q;
  end else begin : gBwdComb
    assign upstream.ack_vld = rspVld_d;
    assign upstream.err     = rspErr_d;
    assign upstream.rd_data = rspData_d;
    assign timeout_evt      = toEvt_d;
  end

  assign busy       = (state_q != IDLE);
  assign proto_viol = protoViol_q;

endmodule

// File: tb/tb_regdisp_multi_disp.sv
// Directed bench: dutA has no pipeline registers and a 16-cycle timeout,
// dutB adds a forward register on channel 1 and a backward register.
module tb_regdisp_multi_disp;

  localparam int AW = 48;
  localparam int DW = 32;
  localparam logic [4*64-1:0] BASES = {64'h3000, 64'h2000, 64'h1000, 64'h0};
  localparam logic [DW-1:0]   DUMMY = 32'hDEAD_BEEF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   nCompared   = 0;
  int   nMismatched = 0;

  logic busyA, toA, pvA, busyB, toB, pvB;

  regdisp_multi_disp_if #(.NCH(1), .AW(AW), .DW(DW)) upA ();
  regdisp_multi_disp_if #(.NCH(4), .AW(AW), .DW(DW)) dnA ();
  regdisp_multi_disp_if #(.NCH(1), .AW(AW), .DW(DW)) upB ();
  regdisp_multi_disp_if #(.NCH(4), .AW(AW), .DW(DW)) dnB ();

  regdisp_multi_disp #(
    .NUM_CH(4), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CH_BASE(BASES),
    .TIMEOUT_CYCLES(16), .DUMMY_READ_DATA(DUMMY)
  ) dutA (
    .regdisp_multi_disp_clk(clk), .regdisp_multi_disp_rst(rst),
    .upstream(upA), .downstream(dnA),
    .busy(busyA), .timeout_evt(toA), .proto_viol(pvA)
  );

  regdisp_multi_disp #(
    .NUM_CH(4), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CH_BASE(BASES),
    .INSERT_FORWARD_FF(4'b0010), .INSERT_BACKWARD_FF(1'b1),
    .TIMEOUT_CYCLES(16), .DUMMY_READ_DATA(DUMMY)
  ) dutB (
    .regdisp_multi_disp_clk(clk), .regdisp_multi_disp_rst(rst),
    .upstream(upB), .downstream(dnB),
    .busy(busyB), .timeout_evt(toB), .proto_viol(pvB)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic idleInputs();
    upA.req_vld = '0; upA.addr = '0; upA.wr_en = '0; upA.rd_en = '0;
    upA.wr_data = '0; upA.non_sec = '0; upA.soft_rst = '0;
    dnA.ack_vld = '0; dnA.err = '0; dnA.rd_data = '0;
    upB.req_vld = '0; upB.addr = '0; upB.wr_en = '0; upB.rd_en = '0;
    upB.wr_data = '0; upB.non_sec = '0; upB.soft_rst = '0;
    dnB.ack_vld = '0; dnB.err = '0; dnB.rd_data = '0;
  endtask

  task automatic test_reset();
    idleInputs();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    nCompared++;
    if ({upA.ack_vld, upA.err, busyA, toA, pvA} !== 5'b0) begin
      nMismatched++;
      $display("[TB] FAIL reset_ctrlA: got %b required 00000", {upA.ack_vld, upA.err, busyA, toA, pvA});
    end
    nCompared++;
    if (upA.rd_data !== 32'h0) begin
      nMismatched++;
      $display("[TB] FAIL reset_rdataA: got %h required 00000000", upA.rd_data);
    end
    nCompared++;
    if ({dnA.req_vld, dnB.req_vld, upB.ack_vld, busyB} !== 10'b0) begin
      nMismatched++;
      $display("[TB] FAIL reset_misc: got %b required 0", {dnA.req_vld, dnB.req_vld, upB.ack_vld, busyB});
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_read_hit();
    upA.req_vld = 1'b1; upA.addr = 48'h2010; upA.rd_en = 1'b1;
    #1;
    nCompared++;
    if (dnA.req_vld !== 4'b0100) begin
      nMismatched++;
      $display("[TB] FAIL hit_req_vld: got %b required 0100", dnA.req_vld);
    end
    nCompared++;
    if (dnA.addr[2*AW +: AW] !== 48'h010) begin
      nMismatched++;
      $display("[TB] FAIL hit_addr: got %h required 010", dnA.addr[2*AW +: AW]);
    end
    nCompared++;
    if (dnA.rd_en !== 4'b0100) begin
      nMismatched++;
      $display("[TB] FAIL hit_rd_en: got %b required 0100", dnA.rd_en);
    end
    @(negedge clk);
    upA.req_vld = 1'b0; upA.addr = '0; upA.rd_en = 1'b0;
    #1;
    nCompared++;
    if ({busyA, upA.ack_vld} !== 2'b10) begin
      nMismatched++;
      $display("[TB] FAIL hit_busy: got %b required 10", {busyA, upA.ack_vld});
    end
    // A stray ack on a channel other than the latched one must be dropped
    repeat (2) @(negedge clk);
    dnA.ack_vld = 4'b1000; dnA.rd_data[3*DW +: DW] = 32'h1234_5678;
    #1;
    nCompared++;
    if (upA.ack_vld !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL hit_foreign_ack: got %b required 0", upA.ack_vld);
    end
    @(negedge clk);
    dnA.ack_vld = 4'b0100; dnA.rd_data = '0; dnA.rd_data[2*DW +: DW] = 32'hCAFE_0001;
    #1;
    nCompared++;
    if ({upA.ack_vld, upA.err, upA.rd_data} !== {2'b10, 32'hCAFE_0001}) begin
      nMismatched++;
      $display("[TB] FAIL hit_rsp: got %b/%b/%h required 1/0/cafe0001", upA.ack_vld, upA.err, upA.rd_data);
    end
    @(negedge clk);
    dnA.ack_vld = '0; dnA.rd_data = '0;
    #1;
    nCompared++;
    if ({busyA, upA.ack_vld, upA.rd_data} !== 34'b0) begin
      nMismatched++;
      $display("[TB] FAIL hit_done: got %b/%b/%h required 0/0/0", busyA, upA.ack_vld, upA.rd_data);
    end
  endtask

  task automatic test_miss();
    upA.req_vld = 1'b1; upA.addr = 48'h8000; upA.rd_en = 1'b1;
    #1;
    nCompared++;
    if ({dnA.req_vld, upA.ack_vld} !== 5'b0) begin
      nMismatched++;
      $display("[TB] FAIL miss_no_fwd: got %b required 00000", {dnA.req_vld, upA.ack_vld});
    end
    @(negedge clk);
    upA.req_vld = 1'b0; upA.addr = '0; upA.rd_en = 1'b0;
    #1;
    nCompared++;
    if ({upA.ack_vld, upA.err, upA.rd_data} !== {2'b11, DUMMY}) begin
      nMismatched++;
      $display("[TB] FAIL miss_rsp: got %b/%b/%h required 1/1/deadbeef", upA.ack_vld, upA.err, upA.rd_data);
    end
    @(negedge clk);
    nCompared++;
    if ({busyA, upA.ack_vld} !== 2'b00) begin
      nMismatched++;
      $display("[TB] FAIL miss_single_pulse: got %b required 00", {busyA, upA.ack_vld});
    end
  endtask

  task automatic test_timeout();
    int earlyAcks;
    earlyAcks = 0;
    upA.req_vld = 1'b1; upA.addr = 48'h1004; upA.wr_en = 1'b1; upA.wr_data = 32'h0000_1234;
    #1;
    nCompared++;
    if ({dnA.req_vld, dnA.wr_en, dnA.wr_data[DW +: DW]} !== {4'b0010, 4'b0010, 32'h0000_1234}) begin
      nMismatched++;
      $display("[TB] FAIL to_fwd: got %b/%b/%h required 0010/0010/00001234", dnA.req_vld, dnA.wr_en, dnA.wr_data[DW +: DW]);
    end
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      if (k == 1) begin
        upA.req_vld = 1'b0; upA.addr = '0; upA.wr_en = 1'b0; upA.wr_data = '0;
        #1;
      end
      if (upA.ack_vld !== 1'b0 || toA !== 1'b0) earlyAcks++;
    end
    nCompared++;
    if (earlyAcks !== 0) begin
      nMismatched++;
      $display("[TB] FAIL to_early: got %0d early acks required 0", earlyAcks);
    end
    @(negedge clk);
    nCompared++;
    if ({upA.ack_vld, upA.err, toA, upA.rd_data} !== {3'b111, DUMMY}) begin
      nMismatched++;
      $display("[TB] FAIL to_fire: got %b/%b/%b/%h required 1/1/1/deadbeef", upA.ack_vld, upA.err, toA, upA.rd_data);
    end
    @(negedge clk);
    nCompared++;
    if ({busyA, upA.ack_vld, toA} !== 3'b000) begin
      nMismatched++;
      $display("[TB] FAIL to_after: got %b required 000", {busyA, upA.ack_vld, toA});
    end
    repeat (3) @(negedge clk);
    dnA.ack_vld = 4'b0010; dnA.rd_data[DW +: DW] = 32'h0BAD_0BAD;
    #1;
    nCompared++;
    if (upA.ack_vld !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL to_late_ack: got %b required 0", upA.ack_vld);
    end
    @(negedge clk);
    dnA.ack_vld = '0; dnA.rd_data = '0;
  endtask

  task automatic test_proto_viol();
    upA.req_vld = 1'b1; upA.addr = 48'h0040; upA.rd_en = 1'b1;
    @(negedge clk);
    upA.addr = 48'h3000;
    #1;
    nCompared++;
    if (dnA.req_vld !== 4'b0000) begin
      nMismatched++;
      $display("[TB] FAIL pv_no_fwd: got %b required 0000", dnA.req_vld);
    end
    @(negedge clk);
    upA.req_vld = 1'b0; upA.addr = '0; upA.rd_en = 1'b0;
    #1;
    nCompared++;
    if ({pvA, busyA} !== 2'b11) begin
      nMismatched++;
      $display("[TB] FAIL pv_flag: got %b required 11", {pvA, busyA});
    end
    dnA.ack_vld = 4'b0001; dnA.rd_data[0 +: DW] = 32'h00AB_0040;
    #1;
    nCompared++;
    if ({upA.ack_vld, upA.err, upA.rd_data} !== {2'b10, 32'h00AB_0040}) begin
      nMismatched++;
      $display("[TB] FAIL pv_ack: got %b/%b/%h required 1/0/00ab0040", upA.ack_vld, upA.err, upA.rd_data);
    end
    @(negedge clk);
    dnA.ack_vld = '0; dnA.rd_data = '0;
    #1;
    nCompared++;
    if ({pvA, busyA} !== 2'b10) begin
      nMismatched++;
      $display("[TB] FAIL pv_sticky: got %b required 10", {pvA, busyA});
    end
  endtask

  task automatic test_reset_in_wait();
    upA.req_vld = 1'b1; upA.addr = 48'h2000; upA.rd_en = 1'b1;
    @(negedge clk);
    upA.req_vld = 1'b0; upA.addr = '0; upA.rd_en = 1'b0;
    rst = 1'b1;
    #1;
    nCompared++;
    if ({busyA, pvA, toA, upA.ack_vld, dnA.req_vld} !== 8'b0) begin
      nMismatched++;
      $display("[TB] FAIL rw_clear: got %b required 00000000", {busyA, pvA, toA, upA.ack_vld, dnA.req_vld});
    end
    @(negedge clk);
    rst = 1'b0;
    dnA.ack_vld = 4'b0100; dnA.rd_data[2*DW +: DW] = 32'h7777_7777;
    #1;
    nCompared++;
    if ({upA.ack_vld, upA.rd_data} !== 33'b0) begin
      nMismatched++;
      $display("[TB] FAIL rw_late_ack: got %b/%h required 0/0", upA.ack_vld, upA.rd_data);
    end
    @(negedge clk);
    dnA.ack_vld = '0; dnA.rd_data = '0;
  endtask

  task automatic test_pipeline_ff();
    upB.req_vld = 1'b1; upB.addr = 48'h1008; upB.wr_en = 1'b1; upB.wr_data = 32'h0000_55AA;
    #1;
    nCompared++;
    if (dnB.req_vld !== 4'b0000) begin
      nMismatched++;
      $display("[TB] FAIL ff_req_early: got %b required 0000", dnB.req_vld);
    end
    @(negedge clk);
    upB.req_vld = 1'b0; upB.addr = '0; upB.wr_en = 1'b0; upB.wr_data = '0;
    #1;
    nCompared++;
    if ({dnB.req_vld, dnB.addr[AW +: AW], dnB.wr_data[DW +: DW]} !== {4'b0010, 48'h8, 32'h0000_55AA}) begin
      nMismatched++;
      $display("[TB] FAIL ff_req_late: got %b/%h/%h required 0010/8/000055aa", dnB.req_vld, dnB.addr[AW +: AW], dnB.wr_data[DW +: DW]);
    end
    @(negedge clk);
    dnB.ack_vld = 4'b0010; dnB.rd_data[DW +: DW] = 32'h0000_1111;
    #1;
    nCompared++;
    if ({dnB.req_vld, upB.ack_vld, busyB} !== 6'b000001) begin
      nMismatched++;
      $display("[TB] FAIL ff_ack_early: got %b required 000001", {dnB.req_vld, upB.ack_vld, busyB});
    end
    @(negedge clk);
    dnB.ack_vld = '0; dnB.rd_data = '0;
    #1;
    nCompared++;
    if ({upB.ack_vld, upB.err, upB.rd_data, busyB} !== {2'b10, 32'h0000_1111, 1'b0}) begin
      nMismatched++;
      $display("[TB] FAIL ff_ack_late: got %b/%b/%h/%b required 1/0/00001111/0", upB.ack_vld, upB.err, upB.rd_data, busyB);
    end
    @(negedge clk);
    nCompared++;
    if (upB.ack_vld !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL ff_single_pulse: got %b required 0", upB.ack_vld);
    end
    upB.soft_rst = 1'b1;
    @(negedge clk);
    nCompared++;
    if (dnB.soft_rst !== 4'b1111) begin
      nMismatched++;
      $display("[TB] FAIL ff_soft_rst: got %b required 1111", dnB.soft_rst);
    end
    upB.soft_rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_read_hit();
    test_miss();
    test_timeout();
    test_proto_viol();
    test_reset_in_wait();
    test_pipeline_ff();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
